// File: rtl/csr_bridge_if.sv
// Wishbone slave port plus CSR initiator port of the bridge, bundled for module connection.
interface csr_bridge_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic [14:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do;
  logic [31:0] csr_di;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, csr_di,
    output wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, csr_di,
    input  wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
  );
endinterface

// File: rtl/csr_bridge.sv
// Wishbone-to-CSR bridge: one CSR write (ack after 2 cycles) or read (ack after 3+RD_WAIT).
// Single outstanding request; cyc dropping mid-read aborts without ack or capture.
module csr_bridge #(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  csr_bridge_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, ACK} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

  state_t     state;
  logic [2:0] wait_cnt;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.wb_adr_i[31:17], bus.wb_adr_i[1:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= 32'd0;
      bus.csr_a    <= 15'd0;
      bus.csr_we   <= 1'b0;
      bus.csr_do   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.wb_ack_o <= 1'b0;
          bus.csr_we   <= 1'b0;
          if (bus.wb_cyc_i && bus.wb_stb_i) begin
            bus.csr_a  <= bus.wb_adr_i[16:2];
            bus.csr_do <= bus.wb_dat_i;
            bus.csr_we <= bus.wb_we_i;
            state      <= bus.wb_we_i ? WRITE : READ;
          end
        end
        WRITE: begin
          // The CSR write is committed this cycle regardless; only the ack depends on cyc.
          bus.csr_we <= 1'b0;
          if (bus.wb_cyc_i) begin
            bus.wb_ack_o <= 1'b1;
            state        <= ACK;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (!bus.wb_cyc_i) begin
            state <= IDLE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          // Entered even for RD_WAIT=0: the first RWAIT cycle is when peripheral data is valid.
          if (!bus.wb_cyc_i) begin
            state <= IDLE;
          end else if (wait_cnt == 3'd0) begin
            bus.wb_dat_o <= bus.csr_di;
            bus.wb_ack_o <= 1'b1;
            state        <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          bus.wb_ack_o <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_bridge.sv
// Bench for csr_bridge: RD_WAIT=0 and RD_WAIT=2 instances, table vectors, corner sequences, random traffic.
module tb_csr_bridge;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  csr_bridge_if if0 ();
  csr_bridge_if if2 ();

  csr_bridge #(.RD_WAIT(0)) dut0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if0.slave));
  csr_bridge #(.RD_WAIT(2)) dut2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if2.slave));

  logic        tgt = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat = 32'd0;

  assign if0.wb_adr_i = adr;
  assign if2.wb_adr_i = adr;
  assign if0.wb_dat_i = dat;
  assign if2.wb_dat_i = dat;
  assign if0.wb_we_i  = we;
  assign if2.wb_we_i  = we;
  assign if0.wb_cyc_i = cyc & ~tgt;
  assign if0.wb_stb_i = stb & ~tgt;
  assign if2.wb_cyc_i = cyc & tgt;
  assign if2.wb_stb_i = stb & tgt;

  logic        m_ack, m_we;
  logic [31:0] m_dat_o, m_do;
  logic [14:0] m_a;
  assign m_ack   = tgt ? if2.wb_ack_o : if0.wb_ack_o;
  assign m_dat_o = tgt ? if2.wb_dat_o : if0.wb_dat_o;
  assign m_we    = tgt ? if2.csr_we   : if0.csr_we;
  assign m_a     = tgt ? if2.csr_a    : if0.csr_a;
  assign m_do    = tgt ? if2.csr_do   : if0.csr_do;

  // Peripheral model: writes sampled with csr_we, read data registered one cycle after csr_a.
  logic [31:0] pmem [0:32767];
  logic [31:0] rdq0 = 32'd0;
  logic [31:0] rdq2 = 32'd0;
  logic        pmem_init = 1'b0;
  assign if0.csr_di = rdq0;
  assign if2.csr_di = rdq2;

  always @(posedge sys_clk) begin
    if (!pmem_init) begin
      for (int i = 0; i < 32768; i++) pmem[i] <= 32'd0;
      pmem[2]   <= 32'h5;
      pmem_init <= 1'b1;
    end else begin
      if (if0.csr_we) pmem[if0.csr_a] <= if0.csr_do;
      if (if2.csr_we) pmem[if2.csr_a] <= if2.csr_do;
    end
    rdq0 <= pmem[if0.csr_a];
    rdq2 <= pmem[if2.csr_a];
  end

  int          we_cnt = 0;
  logic [14:0] pa_last = 15'd0;
  logic [31:0] pdo_last = 32'd0;
  always @(negedge sys_clk) begin
    if (m_we) begin
      we_cnt   = we_cnt + 1;
      pa_last  = m_a;
      pdo_last = m_do;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One Wishbone transaction on the selected DUT; latency counted in edges from the strobe-sampling edge.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output int pulses, output int achg);
    int w0;
    logic [14:0] ew;
    ew = a[16:2];
    @(posedge sys_clk); #1;
    w0 = we_cnt;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    lat = -1; rd = 32'd0; achg = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge sys_clk); #1;
      if (m_a !== ew) achg++;
      if (m_ack) begin
        lat = c;
        rd = m_dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge sys_clk);
    pulses = we_cnt - w0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [14:0] ea;
    logic [31:0] erd;
    int          elat;
  } vec_t;

  logic [31:0] ref_mem [0:32767];
  logic [31:0] last_rd [2];

  initial begin
    vec_t        tbl [8];
    int          lat, pulses, achg, a1, a2, extra, w0;
    logic [31:0] rd, a, d;
    logic [14:0] word;
    bit          w;

    for (int i = 0; i < 32768; i++) ref_mem[i] = 32'd0;
    ref_mem[2] = 32'h5;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    tbl[0] = '{1'b1, 32'h0000_0004, 32'h0000_0364, 15'h0001, 32'h0, 2};
    tbl[1] = '{1'b0, 32'h0000_0008, 32'h0,         15'h0002, 32'h0000_0005, 3};
    tbl[2] = '{1'b0, 32'h0000_0004, 32'h0,         15'h0001, 32'h0000_0364, 3};
    tbl[3] = '{1'b1, 32'hFFFE_7FFF, 32'hDEAD_BEEF, 15'h1FFF, 32'h0, 2};
    tbl[4] = '{1'b0, 32'h0000_7FFC, 32'h0,         15'h1FFF, 32'hDEAD_BEEF, 3};
    tbl[5] = '{1'b1, 32'h0001_FFFC, 32'hA5A5_5A5A, 15'h7FFF, 32'h0, 2};
    tbl[6] = '{1'b0, 32'h0001_FFFF, 32'h0,         15'h7FFF, 32'hA5A5_5A5A, 3};
    tbl[7] = '{1'b0, 32'h0000_0000, 32'h0,         15'h0000, 32'h0, 3};

    #2;
    chk("rst0_ack",  {31'd0, if0.wb_ack_o}, 32'd0);
    chk("rst0_dat",  if0.wb_dat_o, 32'd0);
    chk("rst0_a",    {17'd0, if0.csr_a}, 32'd0);
    chk("rst0_we",   {31'd0, if0.csr_we}, 32'd0);
    chk("rst0_do",   if0.csr_do, 32'd0);
    chk("rst2_ack",  {31'd0, if2.wb_ack_o}, 32'd0);
    chk("rst2_dat",  if2.wb_dat_o, 32'd0);
    chk("rst2_a",    {17'd0, if2.csr_a}, 32'd0);
    chk("rst2_we",   {31'd0, if2.csr_we}, 32'd0);
    chk("rst2_do",   if2.csr_do, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    tgt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].w, tbl[i].adr, tbl[i].dat, lat, rd, pulses, achg);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
      chk($sformatf("tbl%0d_pulses", i), 32'(pulses), tbl[i].w ? 32'd1 : 32'd0);
      chk($sformatf("tbl%0d_csr_a", i), 32'(achg), 32'd0);
      if (tbl[i].w) begin
        chk($sformatf("tbl%0d_pa", i), {17'd0, pa_last}, {17'd0, tbl[i].ea});
        chk($sformatf("tbl%0d_pdo", i), pdo_last, tbl[i].dat);
        chk($sformatf("tbl%0d_dat_hold", i), rd, last_rd[0]);
        ref_mem[tbl[i].ea] = tbl[i].dat;
      end else begin
        chk($sformatf("tbl%0d_rd", i), rd, tbl[i].erd);
        last_rd[0] = tbl[i].erd;
      end
    end

    // Back-to-back write then read with strobe held high throughout.
    tgt = 1'b0;
    @(posedge sys_clk); #1;
    w0 = we_cnt;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0040; dat = 32'h0000_1234;
    a1 = -1; a2 = -1; extra = 0; rd = 32'd0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack) begin
        if (a1 < 0) begin
          a1 = c;
          we = 1'b0;
        end else begin
          a2 = c;
          rd = m_dat_o;
          cyc = 1'b0; stb = 1'b0;
          break;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack) extra++;
    end
    chk("b2b_ack1", 32'(a1), 32'd2);
    chk("b2b_ack2", 32'(a2), 32'd6);
    chk("b2b_extra_ack", 32'(extra), 32'd0);
    chk("b2b_pulses", 32'(we_cnt - w0), 32'd1);
    chk("b2b_rd", rd, 32'h0000_1234);
    ref_mem[16] = 32'h0000_1234;
    last_rd[0] = 32'h0000_1234;

    // Abort: cyc dropped while in READ.
    @(posedge sys_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0008;
    @(posedge sys_clk); #1;
    cyc = 1'b0; stb = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge sys_clk); #1;
      if (m_ack) extra++;
    end
    chk("abort_no_ack", 32'(extra), 32'd0);
    chk("abort_dat_hold", m_dat_o, last_rd[0]);
    txn(1'b0, 32'h0000_0008, 32'd0, lat, rd, pulses, achg);
    chk("abort_next_lat", 32'(lat), 32'd3);
    chk("abort_next_rd", rd, ref_mem[2]);
    last_rd[0] = ref_mem[2];

    // RD_WAIT=2 read: ack at 5, csr_a stable throughout.
    tgt = 1'b1;
    txn(1'b0, 32'h0000_0004, 32'd0, lat, rd, pulses, achg);
    chk("rw2_lat", 32'(lat), 32'd5);
    chk("rw2_rd", rd, ref_mem[1]);
    chk("rw2_csr_a_stable", 32'(achg), 32'd0);
    chk("rw2_pulses", 32'(pulses), 32'd0);
    last_rd[1] = ref_mem[1];

    // Asynchronous reset in the middle of an RWAIT cycle.
    @(posedge sys_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_7FFC;
    @(posedge sys_clk);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, m_ack}, 32'd0);
    chk("arst_dat", m_dat_o, 32'd0);
    chk("arst_a", {17'd0, m_a}, 32'd0);
    chk("arst_we", {31'd0, m_we}, 32'd0);
    chk("arst_do", m_do, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    txn(1'b0, 32'h0000_7FFC, 32'd0, lat, rd, pulses, achg);
    chk("arst_next_lat", 32'(lat), 32'd5);
    chk("arst_next_rd", rd, ref_mem[15'h1FFF]);
    last_rd[1] = ref_mem[15'h1FFF];

    // Reset while csr_we is high drops the write.
    tgt = 1'b0;
    @(posedge sys_clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0100; dat = 32'hCAFE_F00D;
    @(posedge sys_clk); #2;
    chk("wrst_we_before", {31'd0, m_we}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("wrst_we_dropped", {31'd0, m_we}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    txn(1'b0, 32'h0000_0100, 32'd0, lat, rd, pulses, achg);
    chk("wrst_next_rd", rd, ref_mem[15'h0040]);
    last_rd[0] = ref_mem[15'h0040];

    // Random traffic on both instances against the reference memory.
    for (int i = 0; i < 60; i++) begin
      tgt  = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      word = 15'($urandom_range(0, 15));
      a    = ($urandom & 32'hFFFE_0003) | {15'd0, word, 2'b00};
      d    = $urandom;
      repeat ($urandom_range(0, 2)) @(posedge sys_clk);
      txn(w, a, d, lat, rd, pulses, achg);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), w ? 32'd2 : (tgt ? 32'd5 : 32'd3));
      chk($sformatf("rnd%0d_pulses", i), 32'(pulses), w ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_csr_a", i), 32'(achg), 32'd0);
      if (w) begin
        chk($sformatf("rnd%0d_pa", i), {17'd0, pa_last}, {17'd0, word});
        chk($sformatf("rnd%0d_pdo", i), pdo_last, d);
        chk($sformatf("rnd%0d_dat_hold", i), rd, last_rd[tgt]);
        ref_mem[word] = d;
      end else begin
        chk($sformatf("rnd%0d_rd", i), rd, ref_mem[word]);
        last_rd[tgt] = ref_mem[word];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
